// File: rtl/ex_stage_muldiv_if.sv
// EX-stage bundle: ID/EX fields and forwarded values in, EX/MEM register and HI/LO out.
interface ex_stage_muldiv_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int REG_DIR_WIDTH = 3
);
   logic                     flush;
   logic                     in_valid;
   logic [1:0]               ALUop;
   logic [5:0]               funct;
   logic                     ALUSrc;
   logic                     RegDst;
   logic                     RegWrite;
   logic [1:0]               Forward_A;
   logic [1:0]               Forward_B;
   logic [DATA_WIDTH-1:0]    readd1;
   logic [DATA_WIDTH-1:0]    readd2;
   logic [DATA_WIDTH-1:0]    SignExtendOut;
   logic [DATA_WIDTH-1:0]    WBData;
   logic [DATA_WIDTH-1:0]    Address;
   logic [REG_DIR_WIDTH-1:0] RegDst1;
   logic [REG_DIR_WIDTH-1:0] RegDst2;
   logic                     Stall;
   logic                     ex_valid;
   logic                     ex_wen;
   logic [DATA_WIDTH-1:0]    ALUResult;
   logic [REG_DIR_WIDTH-1:0] WriteReg;
   logic [DATA_WIDTH-1:0]    StoreData;
   logic [DATA_WIDTH-1:0]    HI;
   logic [DATA_WIDTH-1:0]    LO;

   modport master (
      output flush, in_valid, ALUop, funct, ALUSrc, RegDst, RegWrite,
             Forward_A, Forward_B, readd1, readd2, SignExtendOut, WBData,
             Address, RegDst1, RegDst2,
      input  Stall, ex_valid, ex_wen, ALUResult, WriteReg, StoreData, HI, LO
   );

   modport slave (
      input  flush, in_valid, ALUop, funct, ALUSrc, RegDst, RegWrite,
             Forward_A, Forward_B, readd1, readd2, SignExtendOut, WBData,
             Address, RegDst1, RegDst2,
      output Stall, ex_valid, ex_wen, ALUResult, WriteReg, StoreData, HI, LO
   );
endinterface

// File: rtl/ex_stage_muldiv.sv
// Execute stage with operand forwarding, ALU and an iterative unsigned mul/div unit.
// The registered outputs form the EX/MEM pipeline register.
module ex_stage_muldiv #(
   parameter int DATA_WIDTH    = 8,
   parameter int REG_DIR_WIDTH = 3
) (
   input logic               clk,
   input logic               reset,
   ex_stage_muldiv_if.slave  bus
);
   localparam int DW = DATA_WIDTH;
   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                   r_state, w_state_nxt;
   logic [CW-1:0]            r_count;
   logic                     r_is_div;
   logic [DW-1:0]            r_acc, r_mq, r_md;
   logic [DW-1:0]            r_hi, r_lo;
   logic                     r_ex_valid, r_ex_wen;
   logic [DW-1:0]            r_alu_result, r_store_data;
   logic [REG_DIR_WIDTH-1:0] r_write_reg;

   logic [DW-1:0] w_a, w_bfwd, w_b, w_res;
   logic          w_is_md, w_start, w_stall, w_last;
   logic [DW:0]   w_sum, w_shift;
   logic [DW-1:0] w_diff, w_step_acc, w_step_mq;
   logic          w_ge;

   always_comb begin
      w_a = bus.readd1;
      case (bus.Forward_A)
         2'd1:    w_a = bus.WBData;
         2'd2:    w_a = bus.Address;
         2'd3:    w_a = '0;
         default: w_a = bus.readd1;
      endcase
      w_bfwd = bus.readd2;
      case (bus.Forward_B)
         2'd1:    w_bfwd = bus.WBData;
         2'd2:    w_bfwd = bus.Address;
         2'd3:    w_bfwd = '0;
         default: w_bfwd = bus.readd2;
      endcase
      w_b = bus.ALUSrc ? bus.SignExtendOut : w_bfwd;
   end

   assign w_is_md = (bus.ALUop == 2'b10) && ((bus.funct == F_MULTU) || (bus.funct == F_DIVU));

   always_comb begin
      w_res = '0;
      case (bus.ALUop)
         2'b00: w_res = w_a + w_b;
         2'b01: w_res = w_a - w_b;
         2'b11: w_res = w_a | w_b;
         default: begin
            case (bus.funct)
               F_ADD:   w_res = w_a + w_b;
               F_SUB:   w_res = w_a - w_b;
               F_AND:   w_res = w_a & w_b;
               F_OR:    w_res = w_a | w_b;
               F_SLT:   w_res = {{(DW-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
               F_MFHI:  w_res = r_hi;
               F_MFLO:  w_res = r_lo;
               default: w_res = '0;
            endcase
         end
      endcase
   end

   // acc:mq is the double-width working pair; multiply shifts right, divide shifts left.
   always_comb begin
      w_sum   = {1'b0, r_acc} + {1'b0, (r_mq[0] ? r_md : {DW{1'b0}})};
      w_shift = {r_acc, r_mq[DW-1]};
      w_ge    = w_shift >= {1'b0, r_md};
      w_diff  = w_shift[DW-1:0] - r_md;
      if (r_is_div) begin
         w_step_acc = w_ge ? w_diff : w_shift[DW-1:0];
         w_step_mq  = {r_mq[DW-2:0], w_ge};
      end else begin
         w_step_acc = w_sum[DW:1];
         w_step_mq  = {w_sum[0], r_mq[DW-1:1]};
      end
   end

   assign w_last  = (r_count == CW'(DW-1));
   assign w_start = bus.in_valid && w_is_md && !bus.flush;

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_stall     = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            w_stall = 1'b1;
            if (bus.flush)   w_state_nxt = S_IDLE;
            else if (w_last) w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_is_div <= 1'b0;
         r_acc    <= '0;
         r_mq     <= '0;
         r_md     <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && w_start) begin
            r_acc    <= '0;
            r_mq     <= w_a;
            r_md     <= w_b;
            r_is_div <= (bus.funct == F_DIVU);
            r_count  <= '0;
         end else if (r_state == S_BUSY && !bus.flush) begin
            r_acc   <= w_step_acc;
            r_mq    <= w_step_mq;
            r_count <= r_count + CW'(1);
            if (w_last) begin
               r_hi <= w_step_acc;
               r_lo <= w_step_mq;
            end
         end
      end
   end

   // Priority: flush kills, then mul/div retirement, then stall bubble, then normal issue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex_valid   <= 1'b0;
         r_ex_wen     <= 1'b0;
         r_alu_result <= '0;
         r_write_reg  <= '0;
         r_store_data <= '0;
      end else if (bus.flush) begin
         r_ex_valid <= 1'b0;
         r_ex_wen   <= 1'b0;
      end else if (r_state == S_DONE) begin
         r_ex_valid <= 1'b1;
         r_ex_wen   <= 1'b0;
      end else if (w_stall) begin
         r_ex_valid <= 1'b0;
         r_ex_wen   <= 1'b0;
      end else if (bus.in_valid) begin
         r_ex_valid   <= 1'b1;
         r_ex_wen     <= bus.RegWrite;
         r_alu_result <= w_res;
         r_write_reg  <= bus.RegDst ? bus.RegDst1 : bus.RegDst2;
         r_store_data <= w_bfwd;
      end else begin
         r_ex_valid <= 1'b0;
      end
   end

   assign bus.Stall     = w_stall;
   assign bus.ex_valid  = r_ex_valid;
   assign bus.ex_wen    = r_ex_wen;
   assign bus.ALUResult = r_alu_result;
   assign bus.WriteReg  = r_write_reg;
   assign bus.StoreData = r_store_data;
   assign bus.HI        = r_hi;
   assign bus.LO        = r_lo;
endmodule
